// File: rtl/pipe_ctrl.sv
// Central sequencer for the IF->ID->EX pipe: stall/enables, valids, MUL hold, halt.
// Optional hold-cycle counter port enabled by PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter logic [3:0]  MUL_OPCODE  = 4'hA,
  parameter int unsigned MUL_LAT     = 4,
  parameter logic [3:0]  HALT_OPCODE = 4'hF,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             halt_req,
  input  logic [3:0]       fetch_opcode,
  output logic             stall,
  output logic             id_en,
  output logic             ex_en,
  output logic             id_valid,
  output logic             ex_valid,
  output logic             ex_busy,
  output logic             halted,
`ifdef PIPE_CTRL_PERF_EN
  output logic [CNT_W-1:0] hold_cnt,
`endif
  output logic [CNT_W-1:0] retire_cnt
);

  localparam logic [3:0] LP_MUL_LD = 4'(MUL_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_HALTED,
    S_SKIP
  } state_t;

  state_t           r_state;
  state_t           w_nxt;
  logic [3:0]       r_ex_cnt;
  logic             r_id_valid;
  logic             r_ex_valid;
  logic [3:0]       r_id_op;
  logic [3:0]       r_ex_op;
  logic             r_halt_by_op;
  logic [CNT_W-1:0] r_retire;
`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] r_hold_cnt;
`endif

  logic w_hold;
  logic w_ex_done;
  logic w_is_halt_op;
  logic w_stop;
  logic w_id_load;
  logic w_id_clr;
  logic w_ex_adv;
  logic w_hbo_ld;

  assign w_hold       = (r_ex_cnt != 4'd0);
  assign w_ex_done    = r_ex_valid && !w_hold;
  assign w_is_halt_op = (fetch_opcode == HALT_OPCODE);
  assign w_stop       = halt_req || w_is_halt_op;

  always_comb begin
    w_nxt     = r_state;
    stall     = 1'b1;
    id_en     = 1'b0;
    ex_en     = 1'b0;
    w_id_load = 1'b0;
    w_id_clr  = 1'b0;
    w_ex_adv  = 1'b0;
    w_hbo_ld  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_nxt = S_RUN;
      end
      S_RUN: begin
        if (!w_hold) begin
          ex_en    = 1'b1;
          w_ex_adv = 1'b1;
          if (w_stop) begin
            // PC stays parked on the instruction that caused the stop
            w_id_clr = 1'b1;
            w_hbo_ld = 1'b1;
            w_nxt    = S_DRAIN;
          end else begin
            stall     = 1'b0;
            id_en     = 1'b1;
            w_id_load = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (!w_hold) begin
          ex_en    = 1'b1;
          w_ex_adv = 1'b1;
          w_id_clr = 1'b1;
          if (!r_id_valid) w_nxt = S_HALTED;
        end
      end
      S_HALTED: begin
        if (start) w_nxt = r_halt_by_op ? S_SKIP : S_RUN;
      end
      S_SKIP: begin
        stall = 1'b0;
        w_nxt = S_RUN;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_ex_cnt     <= '0;
      r_id_valid   <= 1'b0;
      r_ex_valid   <= 1'b0;
      r_id_op      <= '0;
      r_ex_op      <= '0;
      r_halt_by_op <= 1'b0;
      r_retire     <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_hold) r_ex_cnt <= r_ex_cnt - 4'd1;
      if (w_ex_done) r_retire <= r_retire + 1'b1;
      if (w_id_load) begin
        r_id_valid <= 1'b1;
        r_id_op    <= fetch_opcode;
      end else if (w_id_clr) begin
        r_id_valid <= 1'b0;
      end
      if (w_ex_adv) begin
        r_ex_valid <= r_id_valid;
        r_ex_op    <= r_id_op;
        if (r_id_valid && (r_id_op == MUL_OPCODE))
          r_ex_cnt <= LP_MUL_LD;
      end
      // opcode cause wins when halt_req arrives together with HALT
      if (w_hbo_ld) r_halt_by_op <= w_is_halt_op;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_hold_cnt <= '0;
    end else if (w_hold) begin
      r_hold_cnt <= r_hold_cnt + 1'b1;
    end
  end

  assign hold_cnt = r_hold_cnt;
`endif

  assign id_valid   = r_id_valid;
  assign ex_valid   = r_ex_valid;
  assign ex_busy    = w_hold && (r_ex_op == MUL_OPCODE);
  assign halted     = (r_state == S_HALTED);
  assign retire_cnt = r_retire;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a small IF/PC stand-in.
// Vectors: {rstn,start,halt_req} in, {flags,retire_cnt,pc} expected.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic [3:0]  fetch_opcode;
  logic        stall;
  logic        id_en;
  logic        ex_en;
  logic        id_valid;
  logic        ex_valid;
  logic        ex_busy;
  logic        halted;
  logic [15:0] retire_cnt;
`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] hold_cnt;
`endif

  logic [3:0] prog [0:31];
  logic [4:0] pc;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign fetch_opcode = prog[pc];

  always @(posedge clk) begin
    if (!rstn) pc <= '0;
    else if (!stall) pc <= pc + 5'd1;
  end

  pipe_ctrl dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .halt_req     (halt_req),
    .fetch_opcode (fetch_opcode),
    .stall        (stall),
    .id_en        (id_en),
    .ex_en        (ex_en),
    .id_valid     (id_valid),
    .ex_valid     (ex_valid),
    .ex_busy      (ex_busy),
    .halted       (halted),
`ifdef PIPE_CTRL_PERF_EN
    .hold_cnt     (hold_cnt),
`endif
    .retire_cnt   (retire_cnt)
  );

  typedef struct {
    logic       r;
    logic       s;
    logic       h;
    logic [6:0] f;
    int         ret;
    int         pc;
  } vec_t;

  vec_t tv [20];

  function automatic vec_t mk(logic r, logic s, logic h,
                              logic [6:0] f, int ret, int p);
    vec_t v;
    v.r = r; v.s = s; v.h = h;
    v.f = f; v.ret = ret; v.pc = p;
    return v;
  endfunction

  task automatic chk(string nm, string fld, int idx,
                     logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d].%s got=%0h want=%0h",
               nm, idx, fld, act, exp);
    end
  endtask

  // flags = {stall,id_en,ex_en,id_valid,ex_valid,ex_busy,halted}
  task automatic step(string nm, int idx, logic r, logic s, logic h,
                      logic [6:0] f, int ret, int p);
    logic [6:0] got;
    @(negedge clk);
    rstn = r; start = s; halt_req = h;
    #1;
    got = {stall, id_en, ex_en, id_valid, ex_valid, ex_busy, halted};
    chk(nm, "flags", idx, 32'(got), 32'(f));
    chk(nm, "retire", idx, 32'(retire_cnt), ret);
    chk(nm, "pc", idx, 32'(pc), p);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; start = 1'b0; halt_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic load_prog(int sel);
    for (int i = 0; i < 32; i++) prog[i] = 4'h3;
    case (sel)
      0: begin
        prog[0] = 4'h1; prog[1] = 4'h2; prog[2] = 4'hA;
        prog[3] = 4'h4; prog[4] = 4'h5; prog[5] = 4'hF;
        prog[6] = 4'h7; prog[7] = 4'h8; prog[8] = 4'h9;
        prog[9] = 4'hB;
      end
      1: begin
        prog[0] = 4'h1; prog[1] = 4'hA; prog[2] = 4'h3;
        prog[3] = 4'h4; prog[4] = 4'h5;
      end
      default: begin
        prog[0] = 4'h1; prog[1] = 4'h2; prog[2] = 4'hF;
        prog[3] = 4'h4;
      end
    endcase
  endtask

  initial begin
    tv[0]  = mk(1, 0, 0, 7'b1000000, 0, 0);
    tv[1]  = mk(1, 1, 0, 7'b1000000, 0, 0);
    tv[2]  = mk(1, 0, 0, 7'b0110000, 0, 0);
    tv[3]  = mk(1, 0, 0, 7'b0111000, 0, 1);
    tv[4]  = mk(1, 0, 0, 7'b0111100, 0, 2);
    tv[5]  = mk(1, 0, 0, 7'b0111100, 1, 3);
    tv[6]  = mk(1, 0, 0, 7'b1001110, 2, 4);
    tv[7]  = mk(1, 0, 0, 7'b1001110, 2, 4);
    tv[8]  = mk(1, 0, 0, 7'b1001110, 2, 4);
    tv[9]  = mk(1, 0, 0, 7'b0111100, 2, 4);
    tv[10] = mk(1, 0, 0, 7'b1011100, 3, 5);
    tv[11] = mk(1, 0, 0, 7'b1010100, 4, 5);
    tv[12] = mk(1, 0, 0, 7'b1000001, 5, 5);
    tv[13] = mk(1, 1, 0, 7'b1000001, 5, 5);
    tv[14] = mk(1, 0, 0, 7'b0000000, 5, 5);
    tv[15] = mk(1, 0, 0, 7'b0110000, 5, 6);
    tv[16] = mk(1, 0, 0, 7'b0111000, 5, 7);
    tv[17] = mk(1, 0, 0, 7'b0111100, 5, 8);
    tv[18] = mk(1, 0, 0, 7'b0111100, 6, 9);
    tv[19] = mk(1, 0, 0, 7'b0111100, 7, 10);

    // stream, MUL at PC 2, HALT at PC 5, resume via skip
    load_prog(0);
    do_reset();
    for (int i = 0; i < 20; i++)
      step("tbl", i, tv[i].r, tv[i].s, tv[i].h,
           tv[i].f, tv[i].ret, tv[i].pc);

    // halt_req raised during a MUL hold; resume without skip
    load_prog(1);
    do_reset();
    step("hreq", 0,  1, 1, 0, 7'b1000000, 0, 0);
    step("hreq", 1,  1, 0, 0, 7'b0110000, 0, 0);
    step("hreq", 2,  1, 0, 0, 7'b0111000, 0, 1);
    step("hreq", 3,  1, 0, 0, 7'b0111100, 0, 2);
    step("hreq", 4,  1, 0, 1, 7'b1001110, 1, 3);
    step("hreq", 5,  1, 0, 1, 7'b1001110, 1, 3);
    step("hreq", 6,  1, 0, 1, 7'b1001110, 1, 3);
    step("hreq", 7,  1, 0, 1, 7'b1011100, 1, 3);
    step("hreq", 8,  1, 0, 1, 7'b1010100, 2, 3);
    step("hreq", 9,  1, 0, 1, 7'b1000001, 3, 3);
    step("hreq", 10, 1, 1, 0, 7'b1000001, 3, 3);
    step("hreq", 11, 1, 0, 0, 7'b0110000, 3, 3);
    step("hreq", 12, 1, 0, 0, 7'b0111000, 3, 4);

    // halt_req together with HALT opcode: opcode cause wins
    load_prog(2);
    do_reset();
    step("both", 0, 1, 1, 0, 7'b1000000, 0, 0);
    step("both", 1, 1, 0, 0, 7'b0110000, 0, 0);
    step("both", 2, 1, 0, 0, 7'b0111000, 0, 1);
    step("both", 3, 1, 0, 1, 7'b1011100, 0, 2);
    step("both", 4, 1, 0, 1, 7'b1010100, 1, 2);
    step("both", 5, 1, 0, 0, 7'b1000001, 2, 2);
    step("both", 6, 1, 1, 0, 7'b1000001, 2, 2);
    step("both", 7, 1, 0, 0, 7'b0000000, 2, 2);
    step("both", 8, 1, 0, 0, 7'b0110000, 2, 3);

    // reset asserted for one cycle in the middle of a MUL hold
    load_prog(1);
    do_reset();
    step("rst", 0, 1, 1, 0, 7'b1000000, 0, 0);
    step("rst", 1, 1, 0, 0, 7'b0110000, 0, 0);
    step("rst", 2, 1, 0, 0, 7'b0111000, 0, 1);
    step("rst", 3, 1, 0, 0, 7'b0111100, 0, 2);
    step("rst", 4, 0, 0, 0, 7'b1001110, 1, 3);
    step("rst", 5, 1, 0, 0, 7'b1000000, 0, 0);
    step("rst", 6, 1, 0, 0, 7'b1000000, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central sequencer for the 3-stage IF→ID→EX pipeline.
- Drives the IF-stage `stall` and the IF/ID and ID/EX register load enables.
- Tracks per-stage valid bits and a shadow opcode per stage.
- Holds the pipe for multi-cycle MUL ops in EX, and handles halt (HALT opcode or external request): drains, parks, then resumes on `start`.

Parameters:
- MUL_OPCODE, 4'hA, opcode that occupies EX for MUL_LAT cycles
- MUL_LAT, 4, EX occupancy of MUL in cycles; legal range 2..15
- HALT_OPCODE, 4'hF, opcode that stops fetch
- CNT_W, 16, retire counter width

Ports:
- clk  input  1  system clock, rising edge
- rstn  input  1  synchronous active-low reset
- start  input  1  pulse; leaves IDLE or HALTED, ignored in other states
- halt_req  input  1  level; external/debug halt request
- fetch_opcode  input  4  bits [19:16] of the instruction IF currently presents
- stall  output  1  to IF stage; 1 freezes PC (combinational)
- id_en  output  1  IF/ID register load enable (combinational)
- ex_en  output  1  ID/EX register load enable (combinational)
- id_valid  output  1  ID holds a real instruction (registered)
- ex_valid  output  1  EX holds a real instruction (registered)
- ex_busy  output  1  1 while a MUL hold is in progress (ex_cnt != 0)
- halted  output  1  1 in HALTED state (registered)
- retire_cnt  output  CNT_W  completed-instruction count, wraps modulo 2^CNT_W

Behaviour:
- Reset: rstn=0 at a clock edge → state=IDLE; id_valid, ex_valid, ex_cnt, retire_cnt, halt_by_op, id_op, ex_op all 0. This applies in every state, including mid-hold.
- Internal signals:
  - hold = (ex_cnt != 0)
  - ex_done = ex_valid & !hold
  - stop = halt_req | (fetch_opcode == HALT_OPCODE)
- States: IDLE, RUN, DRAIN, HALTED, SKIP.
- Retire: retire_cnt += 1 on every cycle where ex_done=1.
- hold=1 (RUN or DRAIN):
  - stall=1, id_en=0, ex_en=0.
  - ex_cnt decrements; all other state is held.
  - stop is not sampled.
- IDLE:
  - stall=1, id_en=0, ex_en=0.
  - start → RUN.
- RUN, hold=0, stop=0:
  - stall=0, id_en=1, ex_en=1.
  - id_valid←1, id_op←fetch_opcode.
  - ex_valid←id_valid, ex_op←id_op.
  - If id_valid & id_op==MUL_OPCODE: ex_cnt←MUL_LAT-1.
- RUN, hold=0, stop=1:
  - stall=1 in the same cycle, so PC stays on the stopping instruction; id_en=0, ex_en=1.
  - id_valid←0; ID→EX advance and MUL load as in the stop=0 case.
  - halt_by_op←(fetch_opcode==HALT_OPCODE); this takes priority when both causes are present.
  - state→DRAIN.
- DRAIN, hold=0:
  - stall=1, id_en=0, ex_en=1.
  - id_valid←0; ex_valid←id_valid, with MUL load as above.
  - If id_valid==0: state→HALTED (ex_valid becomes 0).
- HALTED:
  - stall=1, enables 0, halted=1.
  - start with halt_by_op=1 → SKIP; start with halt_by_op=0 → RUN.
- SKIP:
  - One cycle: stall=0, id_en=0, ex_en=0, valids stay 0.
  - PC steps past the HALT instruction without executing it; state→RUN.
- MUL in EX occupies exactly MUL_LAT cycles and retires once, on the last of them.
- A single-cycle op retires on its only EX cycle.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- Defined: adds output hold_cnt [CNT_W-1:0], reset 0, incremented on every cycle hold=1, wraps.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset, start, then opcodes 1,2,3,… → stall=0 from the cycle after start; id_valid=1 one cycle later; ex_valid=1 two cycles later; retire_cnt increments every cycle thereafter.
- Stream with MUL at PC 2, MUL_LAT=4 → ex_busy=1 and stall=1 for 3 cycles; PC frozen; retire_cnt rises by exactly 1 over the MUL's 4 EX cycles; normal flow resumes afterwards.
- HALT opcode at PC 5 → stall=1 that cycle; two drain cycles; halted=1; retire_cnt=5; PC=5. Then start → SKIP advances PC to 6; PC 6 enters ID on the next cycle.
- halt_req=1 while a MUL is in EX → hold completes first, then drain, halted=1. Then start → RUN directly with no skip; the instruction at the frozen PC executes.
- halt_req=1 in the same cycle that fetch_opcode==HALT_OPCODE → halt_by_op=1; resume performs SKIP.
- rstn=0 for one cycle during a MUL hold → next cycle: IDLE, stall=1, ex_busy=0, valids 0, retire_cnt=0.
